cache_port_arbiter: RTL and testbench

- Shares one cache instance (70-bit put request, 52-bit get response, valid/ready on both channels) between two requesters, e.g. two cores or an instruction/data pair.
- Arbitrates the request channel round-robin.
- Records the grant order in an internal order FIFO and steers in-order cache responses back to the requester that issued each request.
- Sits between the requester-side rules and the cache wrapper, on the same clock and reset.

---
 rtl/cache_port_arbiter.sv | 115 +++++++++++
 tb/tb_cache_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_arbiter.sv
//------------------------------------------------------------------------------
// cache_port_arbiter: shares one in-order cache between two requesters.
// Round-robin put arbitration; an order FIFO of requester ids steers responses.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cache_port_arbiter #(
  parameter int REQ_W  = 70,
  parameter int RESP_W = 52,
  parameter int DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  // requester 0
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [REQ_W-1:0]           req0_data,
  output logic                       resp0_valid,
  input  logic                       resp0_ready,
  output logic [RESP_W-1:0]          resp0_data,
  // requester 1
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [REQ_W-1:0]           req1_data,
  output logic                       resp1_valid,
  input  logic                       resp1_ready,
  output logic [RESP_W-1:0]          resp1_data,
  // cache side
  output logic                       cache_put_valid,
  input  logic                       cache_put_ready,
  output logic [REQ_W-1:0]           cache_put_request,
  output logic                       cache_get_valid,
  input  logic                       cache_get_ready,
  input  logic [RESP_W-1:0]          cache_get_response,
  // status
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  logic [DEPTH-1:0] r_order;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic             r_last_grant;
  logic             r_proto_err;

  logic w_full;
  logic w_empty;
  logic w_any_req;
  logic w_gnt_id;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full    = (r_count == c_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_any_req = req0_valid | req1_valid;

  // With a lone requester req1_valid alone selects the id; idle falls to id 0.
  assign w_gnt_id  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

  assign cache_put_valid   = w_any_req & ~w_full;
  assign cache_put_request = w_gnt_id ? req1_data : req0_data;
  assign req0_ready        = ~w_gnt_id & cache_put_ready & ~w_full & req0_valid;
  assign req1_ready        =  w_gnt_id & cache_put_ready & ~w_full & req1_valid;
  assign w_push            = cache_put_valid & cache_put_ready;

  assign w_head          = r_order[r_rptr];
  assign resp0_valid     = ~w_empty & ~w_head & cache_get_ready;
  assign resp1_valid     = ~w_empty &  w_head & cache_get_ready;
  assign resp0_data      = cache_get_response;
  assign resp1_data      = cache_get_response;
  assign cache_get_valid = ~w_empty & (w_head ? resp1_ready : resp0_ready);
  assign w_pop           = cache_get_valid & cache_get_ready;

  assign outstanding = r_count;
  assign proto_err   = r_proto_err;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_order      <= '0;
      r_rptr       <= '0;
      r_wptr       <= '0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_order[r_wptr] <= w_gnt_id;
        r_wptr          <= r_wptr + 1'b1;
        r_last_grant    <= w_gnt_id;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A response offered with nothing outstanding is a cache protocol error.
      if (cache_get_ready & w_empty) begin
        r_proto_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_cache_port_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbiter and an in-order cache.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_port_arbiter;

  localparam int REQ_W  = 70;
  localparam int RESP_W = 52;
  localparam int DEPTH  = 4;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              req0_valid, req0_ready, resp0_valid, resp0_ready;
  logic              req1_valid, req1_ready, resp1_valid, resp1_ready;
  logic [REQ_W-1:0]  req0_data, req1_data, cache_put_request;
  logic [RESP_W-1:0] resp0_data, resp1_data, cache_get_response;
  logic              cache_put_valid, cache_put_ready;
  logic              cache_get_valid, cache_get_ready;
  logic [$clog2(DEPTH):0] outstanding;
  logic              proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  cache_port_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .cache_put_valid(cache_put_valid), .cache_put_ready(cache_put_ready),
    .cache_put_request(cache_put_request),
    .cache_get_valid(cache_get_valid), .cache_get_ready(cache_get_ready),
    .cache_get_response(cache_get_response),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  // Reference model: queue of requester ids in grant order, plus cache payload queue.
  int               m_q[$];
  logic [REQ_W-1:0] m_cq[$];
  logic             m_lg;
  logic             m_perr;

  logic             e_gnt, e_put_valid, e_r0rdy, e_r1rdy, e_push;
  logic             e_r0v, e_r1v, e_getv, e_pop;
  logic [REQ_W-1:0] e_put_req;

  task automatic model_eval();
    int head;
    logic full, empty;
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    if (req0_valid && req1_valid) e_gnt = ~m_lg;
    else if (req1_valid)          e_gnt = 1'b1;
    else                          e_gnt = 1'b0;
    e_put_valid = (req0_valid | req1_valid) & ~full;
    e_put_req   = e_gnt ? req1_data : req0_data;
    e_r0rdy     = (e_gnt == 1'b0) & cache_put_ready & ~full & req0_valid;
    e_r1rdy     = (e_gnt == 1'b1) & cache_put_ready & ~full & req1_valid;
    e_push      = e_put_valid & cache_put_ready;
    head        = empty ? 0 : m_q[0];
    e_r0v       = ~empty & (head == 0) & cache_get_ready;
    e_r1v       = ~empty & (head == 1) & cache_get_ready;
    e_getv      = ~empty & ((head == 1) ? resp1_ready : resp0_ready);
    e_pop       = e_getv & cache_get_ready;
  endtask

  task automatic tick();
    logic was_empty;
    model_eval();
    was_empty = (m_q.size() == 0);
    @(posedge CLK);
    if (e_pop) begin
      void'(m_q.pop_front());
      if (m_cq.size() > 0) void'(m_cq.pop_front());
    end
    if (e_push) begin
      m_q.push_back(int'(e_gnt));
      m_cq.push_back(e_put_req);
      m_lg = e_gnt;
    end
    if (cache_get_ready && was_empty) m_perr = 1'b1;
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    resp0_ready = 0; resp1_ready = 0;
    cache_put_ready = 0; cache_get_ready = 0; cache_get_response = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    m_q.delete(); m_cq.delete();
    m_lg = 1'b1; m_perr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (outstanding !== 0 || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: outstanding=%0d proto_err=%b, want 0/0", outstanding, proto_err);
    end
    n_tests++;
    if ({cache_put_valid, cache_get_valid, req0_ready, req1_ready, resp0_valid, resp1_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_handshakes: got %b, want 000000",
               {cache_put_valid, cache_get_valid, req0_ready, req1_ready, resp0_valid, resp1_valid});
    end
  endtask

  task automatic test_single();
    req0_valid = 1; req0_data = 70'h1; cache_put_ready = 1;
    #1;
    n_tests++;
    if (cache_put_request !== 70'h1 || req0_ready !== 1'b1 || cache_put_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_put: req=%h rdy=%b pv=%b, want 1/1/1", cache_put_request, req0_ready, cache_put_valid);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if (outstanding !== 1) begin
      n_fail++;
      $display("FAIL single_outstanding: got %0d want 1", outstanding);
    end
    // last_grant is now 0, so a tie must go to requester 1
    req0_valid = 1; req1_valid = 1; req1_data = 70'h2; cache_put_ready = 0;
    #1;
    n_tests++;
    if (cache_put_request !== 70'h2) begin
      n_fail++;
      $display("FAIL single_last_grant: put_request=%h want 2", cache_put_request);
    end
    idle_inputs();
  endtask

  task automatic test_fill();
    logic exp_id[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    req0_valid = 1; req1_valid = 1; cache_put_ready = 1;
    req0_data = 70'h100; req1_data = 70'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (req0_ready !== ~exp_id[i] || req1_ready !== exp_id[i] ||
          cache_put_request !== (exp_id[i] ? 70'h200 : 70'h100)) begin
        n_fail++;
        $display("FAIL fill_grant%0d: r0=%b r1=%b req=%h, want id %0d", i, req0_ready, req1_ready,
                 cache_put_request, exp_id[i]);
      end
      tick();
    end
    #1;
    n_tests++;
    if (cache_put_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || outstanding !== 4) begin
      n_fail++;
      $display("FAIL fill_full: pv=%b r0=%b r1=%b out=%0d, want 0/0/0/4", cache_put_valid, req0_ready,
               req1_ready, outstanding);
    end
    idle_inputs();
  endtask

  task automatic test_drain();
    logic [RESP_W-1:0] rd[4];
    logic              rid[4];
    rd  = '{52'hA, 52'hB, 52'hC, 52'hD};
    rid = '{1'b0, 1'b1, 1'b0, 1'b1};
    resp0_ready = 1; resp1_ready = 1; cache_get_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cache_get_response = rd[i];
      #1;
      n_tests++;
      if (resp0_valid !== ~rid[i] || resp1_valid !== rid[i] || cache_get_valid !== 1'b1 ||
          (rid[i] ? resp1_data : resp0_data) !== rd[i]) begin
        n_fail++;
        $display("FAIL drain_resp%0d: v0=%b v1=%b gv=%b d0=%h d1=%h, want id %0d data %h", i,
                 resp0_valid, resp1_valid, cache_get_valid, resp0_data, resp1_data, rid[i], rd[i]);
      end
      tick();
    end
    cache_get_ready = 0;
    #1;
    n_tests++;
    if (outstanding !== 0 || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: out=%0d perr=%b, want 0/0", outstanding, proto_err);
    end
    idle_inputs();
  endtask

  task automatic test_head_block();
    do_reset();
    req1_valid = 1; req1_data = 70'h55; cache_put_ready = 1;
    tick();
    idle_inputs();
    cache_get_ready = 1; resp0_ready = 1; resp1_ready = 0;
    #1;
    n_tests++;
    if (cache_get_valid !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL head_block: gv=%b v0=%b v1=%b, want 0/0/1", cache_get_valid, resp0_valid, resp1_valid);
    end
    tick();
    n_tests++;
    if (outstanding !== 1) begin
      n_fail++;
      $display("FAIL head_block_nopop: out=%0d want 1", outstanding);
    end
    resp1_ready = 1;
    #1;
    n_tests++;
    if (cache_get_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL head_release: gv=%b want 1", cache_get_valid);
    end
    tick();
    n_tests++;
    if (outstanding !== 0) begin
      n_fail++;
      $display("FAIL head_release_pop: out=%0d want 0", outstanding);
    end
    idle_inputs();
  endtask

  task automatic test_full_pushpop();
    do_reset();
    req0_valid = 1; cache_put_ready = 1; req0_data = 70'h7;
    for (int i = 0; i < 4; i++) tick();
    cache_get_ready = 1; resp0_ready = 1;
    #1;
    n_tests++;
    if (req0_ready !== 1'b0 || cache_put_valid !== 1'b0 || cache_get_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pushpop: r0=%b pv=%b gv=%b, want 0/0/1", req0_ready, cache_put_valid, cache_get_valid);
    end
    tick();
    n_tests++;
    if (outstanding !== 3 || req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pushpop_after: out=%0d r0=%b, want 3/1", outstanding, req0_ready);
    end
    tick();
    n_tests++;
    if (outstanding !== 3) begin
      n_fail++;
      $display("FAIL push_pop_same_cycle: out=%0d want 3", outstanding);
    end
    req0_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    idle_inputs();
  endtask

  task automatic test_proto_err();
    do_reset();
    cache_get_ready = 1;
    #1;
    n_tests++;
    if (cache_get_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_noaccept: gv=%b want 0", cache_get_valid);
    end
    tick();
    cache_get_ready = 0;
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_set: perr=%b want 1", proto_err);
    end
    tick(); tick();
    n_tests++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_sticky: perr=%b want 1", proto_err);
    end
    do_reset();
    n_tests++;
    if (proto_err !== 1'b0 || outstanding !== 0) begin
      n_fail++;
      $display("FAIL proto_reset: perr=%b out=%0d, want 0/0", proto_err, outstanding);
    end
  endtask

  task automatic test_random();
    logic [RESP_W-1:0] exp_d;
    int                errs;
    do_reset();
    errs = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req0_valid      = ($urandom_range(0, 3) != 0);
      req1_valid      = ($urandom_range(0, 3) != 0);
      req0_data       = {$urandom(), $urandom(), $urandom()};
      req1_data       = {$urandom(), $urandom(), $urandom()};
      cache_put_ready = ($urandom_range(0, 2) != 0);
      resp0_ready     = ($urandom_range(0, 2) != 0);
      resp1_ready     = ($urandom_range(0, 2) != 0);
      if (m_q.size() > 0) cache_get_ready = ($urandom_range(0, 2) != 0);
      else                cache_get_ready = ($urandom_range(0, 39) == 0);
      if (m_cq.size() > 0) begin
        exp_d = m_cq[0][RESP_W-1:0];
        cache_get_response = exp_d;
      end else begin
        exp_d = {$urandom(), $urandom()};
        cache_get_response = exp_d;
      end
      #1;
      model_eval();
      n_tests++;
      if (cache_put_valid !== e_put_valid || req0_ready !== e_r0rdy || req1_ready !== e_r1rdy ||
          cache_put_request !== e_put_req || resp0_valid !== e_r0v || resp1_valid !== e_r1v ||
          cache_get_valid !== e_getv || outstanding !== m_q.size() || proto_err !== m_perr ||
          (e_r0v && resp0_data !== exp_d) || (e_r1v && resp1_data !== exp_d)) begin
        n_fail++;
        errs++;
        if (errs <= 5)
          $display("FAIL random_cyc%0d: pv=%b r0=%b r1=%b v0=%b v1=%b gv=%b out=%0d perr=%b, want %b %b %b %b %b %b %0d %b",
                   cyc, cache_put_valid, req0_ready, req1_ready, resp0_valid, resp1_valid, cache_get_valid,
                   outstanding, proto_err, e_put_valid, e_r0rdy, e_r1rdy, e_r0v, e_r1v, e_getv,
                   m_q.size(), m_perr);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    RST_N = 1'b0;
    idle_inputs();
    m_lg = 1'b1; m_perr = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_head_block();
    test_full_pushpop();
    test_proto_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
